// File: rtl/dmem_pkg.sv
// Shared types and default constants for the MEM-stage data-memory responder.
package dmem_pkg;

    localparam int unsigned DM_DEPTH_WORDS = 256;
    localparam int unsigned DM_LATENCY     = 2;
    localparam int unsigned DM_ADDR_W      = 32;
    localparam int unsigned DM_DATA_W      = 32;
    localparam int unsigned DM_BE_W        = 4;
    localparam int unsigned DM_CNT_W       = 4;

    typedef enum logic [1:0] {
        DM_IDLE = 2'd0,
        DM_WAIT = 2'd1,
        DM_RESP = 2'd2
    } dm_state_e;

    typedef struct packed {
        logic                 we;
        logic [DM_ADDR_W-1:0] addr;
        logic [DM_DATA_W-1:0] wdata;
        logic [DM_BE_W-1:0]   be;
    } dm_req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the MEM stage (master) and the data-memory responder (slave).
interface dmem_responder_if #(
    parameter int unsigned ADDR_W = 32
) ();
    import dmem_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [ADDR_W-1:0]    req_addr;
    logic [DM_DATA_W-1:0] req_wdata;
    logic [DM_BE_W-1:0]   req_be;
    logic                 rsp_valid;
    logic [DM_DATA_W-1:0] rsp_rdata;
    logic                 rsp_err;
    logic                 stall;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, stall
    );

endinterface

// File: rtl/dmem_array.sv
// Single-port word RAM with byte-lane writes and a registered, clearable read port.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DM_DEPTH_WORDS,
    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_i,
    input  logic                 rd_i,
    input  logic [DM_BE_W-1:0]   wbe_i,
    input  logic [IDX_W-1:0]     idx_i,
    input  logic [DM_DATA_W-1:0] wdata_i,
    output logic [DM_DATA_W-1:0] rdata_o
);

    logic [DM_DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DM_DATA_W-1:0] rdata_q;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int unsigned b = 0; b < DM_BE_W; b++) begin
                if (wbe_i[b]) begin
                    mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Non-read accesses (stores, errors) return zero and hold until the next access.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (en_i) begin
            rdata_q <= rd_i ? mem_q[idx_i] : '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Variable-latency data-memory target for the MEM stage; stalls IF..MEM until its response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DM_DEPTH_WORDS,
    parameter int unsigned LATENCY     = DM_LATENCY,
    parameter int unsigned ADDR_W      = DM_ADDR_W
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [DM_CNT_W-1:0] CNT_LOAD =
        (LATENCY >= 2) ? DM_CNT_W'(LATENCY - 2) : '0;

    dm_state_e           state_q, state_d;
    logic [DM_CNT_W-1:0] cnt_q, cnt_d;
    dm_req_t             req_q;
    logic                rsp_valid_q;
    logic                rsp_err_q;

    dm_req_t             cur_req_c;
    logic                accept_c;
    logic                err_c;
    logic                commit_c;
    logic                ready_c;
    logic                stall_c;
    logic [DM_ADDR_W-1:0] word_idx_c;

    // In IDLE the live bus is the request; afterwards the captured copy is.
    always_comb begin
        cur_req_c = req_q;
        if (state_q == DM_IDLE) begin
            cur_req_c.we    = bus.req_we;
            cur_req_c.addr  = DM_ADDR_W'(bus.req_addr);
            cur_req_c.wdata = bus.req_wdata;
            cur_req_c.be    = bus.req_be;
        end
    end

    assign accept_c   = ready_c && bus.req_valid;
    assign word_idx_c = cur_req_c.addr >> 2;
    assign err_c      = (cur_req_c.addr[1:0] != 2'b00) ||
                        (word_idx_c >= DM_ADDR_W'(DEPTH_WORDS));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            DM_IDLE: begin
                if (accept_c) begin
                    if (LATENCY == 1) begin
                        state_d = DM_RESP;
                    end else begin
                        state_d = DM_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            DM_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = DM_RESP;
                end else begin
                    cnt_d = cnt_q - DM_CNT_W'(1);
                end
            end
            DM_RESP: state_d = DM_IDLE;
            default: state_d = DM_IDLE;
        endcase
    end

    // Commit happens on the edge entering RESP; reset always wins so a pending store is dropped.
    always_comb begin
        ready_c  = 1'b0;
        stall_c  = 1'b0;
        commit_c = 1'b0;
        if (!rst) begin
            ready_c  = (state_q == DM_IDLE);
            stall_c  = ((state_q == DM_IDLE) && bus.req_valid) || (state_q == DM_WAIT);
            commit_c = ((state_q == DM_IDLE) && bus.req_valid && (LATENCY == 1)) ||
                       ((state_q == DM_WAIT) && (cnt_q == '0));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            req_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            rsp_valid_q <= commit_c;
            if (accept_c) begin
                req_q <= cur_req_c;
            end
            if (commit_c) begin
                rsp_err_q <= err_c;
            end
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .en_i    (commit_c),
        .rd_i    (!cur_req_c.we && !err_c),
        .wbe_i   (cur_req_c.be & {DM_BE_W{cur_req_c.we && !err_c}}),
        .idx_i   (cur_req_c.addr[IDX_W+1:2]),
        .wdata_i (cur_req_c.wdata),
        .rdata_o (bus.rsp_rdata)
    );

    assign bus.req_ready = ready_c;
    assign bus.stall     = stall_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule
